execute_stage_mdu: RTL and testbench
====================================

# execute_stage_mdu

Registered, parametrised execute stage: ALU path, branch-target adder and register-destination mux from the single-cycle execute step, plus an iterative unsigned multiply/divide unit (MDU) with HI/LO registers. All results are captured in an internal EX/MEM output register. The block sits between the ID/EX and MEM stages of the pipelined MIPS core. It raises `busy` to stall upstream while a multi-cycle op runs or while the downstream stage stalls.

## Interface
- DATA_W, 32, datapath width (even, ≥8)
- REG_W, 5, register-address width
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-low
- in_valid  in  1  ID/EX holds a valid instruction
- stall_in  in  1  MEM stage cannot accept; hold outputs
- flush  in  1  squash current output and abort MDU op
- aluSrc, regDst  in  1  operand-2 select (1 = signExtend), dest select (0 = regDst1, 1 = regDst2)
- ALUOp  in  6  to existing alu_control, funct = signExtend[5:0]
- mduOp  in  3  000 none, 001 MULTU, 010 DIVU, 011 MFHI, 100 MFLO, others = none
- pcPlusFour, reg1, reg2, signExtend  in  DATA_W  operands
- regDst1, regDst2  in  REG_W  candidate destinations
- busy  out  1  upstream must hold ID/EX
- out_valid  out  1  EX/MEM register holds a valid instruction
- addResult, aluResult, reg2Out  out  DATA_W  registered branch target, result, store data
- zero  out  1  registered ALU zero flag
- muxRegDstOut  out  REG_W  registered destination

## Operation
- Accept when in_valid && !busy && !flush.
- Any output register load ends with out_valid=1 and the load contents described below.
- Non-MDU op: on accept, load addResult=pcPlusFour+(signExtend<<2) mod 2^DATA_W, plus aluResult, zero, reg2Out=reg2 and muxRegDstOut.
- MFHI/MFLO: as non-MDU, but aluResult=HI/LO and zero=(aluResult==0).
- MULTU: FSM IDLE→MUL, counter 0..DATA_W-1, one shift-add step per cycle. The result is {HI,LO}=reg1*reg2, 2·DATA_W bits, unsigned.
- DIVU: IDLE→DIV, restoring, one quotient bit per cycle, giving LO=reg1/reg2 and HI=reg1%reg2. Divisor 0 skips iteration and goes straight to DONE with LO=all-ones, HI=reg1.
- DONE: write HI/LO, load the output register with aluResult=LO, zero=0, muxRegDstOut=0 (no writeback), addResult/reg2Out from the latched instruction. Then return to IDLE.
- Operands and instruction fields are latched at accept; inputs are ignored while busy.
- busy = (state≠IDLE) || stall_in.
- stall_in=1: output registers hold. The FSM keeps iterating but holds in DONE until stall_in=0.
- flush=1 (priority over everything but reset): next edge out_valid=0, FSM→IDLE, HI/LO unchanged, no accept that cycle.
- Reset (rst=0 at edge): all outputs 0, HI=LO=0, FSM IDLE, counter 0.

## Timing
- ALU/MFHI/MFLO latency: accepted at edge E0, outputs valid after E0.
- MULTU/DIVU accepted at E0:
  - States MUL/DIV after E0 through E(DATA_W-1).
  - State DONE after E(DATA_W).
  - At E(DATA_W+1), HI/LO are written, out_valid=1 and the FSM goes to IDLE.
  - busy is high from after E0 until after E(DATA_W+1); next accept is at E(DATA_W+2) at the earliest.
- DIVU by zero: DONE after E0, result at E1.
- out_valid stays 1 across consecutive accepts. It drops to 0 after an edge with no accept, no DONE completion and no stall.
- Back-to-back ALU ops: one per cycle.
- Wrap-around: the branch adder and ALU discard carry out.

## Test plan
- Reset: hold rst=0 for 2 cycles with random inputs → all outputs 0, busy=0. Then MFHI → aluResult=0.
- ALU add: reg1=5, signExtend funct=0x20 with ALUOp R-type, reg2=7, regDst=1, regDst2=3 → next cycle aluResult=12, zero=0, muxRegDstOut=3, out_valid=1. Issue 3 more back-to-back → one result per cycle.
- MULTU 0xFFFFFFFF×0xFFFFFFFF (DATA_W=32) → busy for 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001. MFHI/MFLO return them.
- DIVU 100/7 → LO=14, HI=2 after 33 cycles. DIVU 9/0 → next cycle LO=0xFFFFFFFF, HI=9.
- stall_in asserted mid-MULTU and held 5 cycles past completion → FSM waits in DONE, outputs unchanged. Release → result appears at the next edge.
- flush 10 cycles into DIVU → out_valid=0, busy=0 next cycle, HI/LO keep prior values. Reset mid-MULTU behaves the same, with HI/LO=0.

Source files
------------

// File: rtl/execute_stage_mdu.sv
// Execute stage of the pipelined MIPS core: ALU, branch-target adder,
// destination mux and an iterative unsigned multiply/divide unit with
// HI/LO registers. All results land in a registered EX/MEM output stage.
module execute_stage_mdu #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              stall_in,
    input  logic              flush,
    input  logic              aluSrc,
    input  logic              regDst,
    input  logic [5:0]        ALUOp,
    input  logic [2:0]        mduOp,
    input  logic [DATA_W-1:0] pcPlusFour,
    input  logic [DATA_W-1:0] reg1,
    input  logic [DATA_W-1:0] reg2,
    input  logic [DATA_W-1:0] signExtend,
    input  logic [REG_W-1:0]  regDst1,
    input  logic [REG_W-1:0]  regDst2,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] addResult,
    output logic [DATA_W-1:0] aluResult,
    output logic [DATA_W-1:0] reg2Out,
    output logic              zero,
    output logic [REG_W-1:0]  muxRegDstOut
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;
    // Working registers: wa = upper product / remainder, wb = lower product / quotient,
    // wd = multiplicand / divisor.
    logic [DATA_W-1:0]   wa;
    logic [DATA_W-1:0]   wb;
    logic [DATA_W-1:0]   wd;
    logic [DATA_W-1:0]   lat_add;
    logic [DATA_W-1:0]   lat_reg2;

    logic [DATA_W-1:0]   op2;
    logic [DATA_W-1:0]   br_target;
    logic [DATA_W-1:0]   alu_out;
    logic [DATA_W-1:0]   ex_result;
    logic                is_mul;
    logic                is_div;
    logic                accept;

    // ALU: ALUOp 0 selects an R-type operation from funct, otherwise ALUOp is the opcode.
    function automatic logic [DATA_W-1:0] alu_calc(
        input logic [5:0]        op,
        input logic [5:0]        funct,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        logic [DATA_W-1:0]        r;
        sa = a;
        sb = b;
        r  = a + b;
        if (op == 6'h00) begin
            case (funct)
                6'h20, 6'h21: r = a + b;
                6'h22, 6'h23: r = a - b;
                6'h24:        r = a & b;
                6'h25:        r = a | b;
                6'h26:        r = a ^ b;
                6'h27:        r = ~(a | b);
                6'h2A:        r = {{(DATA_W-1){1'b0}}, (sa < sb)};
                6'h2B:        r = {{(DATA_W-1){1'b0}}, (a < b)};
                6'h04:        r = b << a[CNT_W-1:0];
                6'h06:        r = b >> a[CNT_W-1:0];
                6'h07:        r = sb >>> a[CNT_W-1:0];
                default:      r = a + b;
            endcase
        end else begin
            case (op)
                6'h04, 6'h05: r = a - b;
                6'h0A:        r = {{(DATA_W-1){1'b0}}, (sa < sb)};
                6'h0B:        r = {{(DATA_W-1){1'b0}}, (a < b)};
                6'h0C:        r = a & b;
                6'h0D:        r = a | b;
                6'h0E:        r = a ^ b;
                6'h0F:        r = b << (DATA_W / 2);
                default:      r = a + b;
            endcase
        end
        return r;
    endfunction

    // One shift-add step: conditionally add the multiplicand to the upper half,
    // then shift the whole product right by one, keeping the carry.
    function automatic logic [2*DATA_W-1:0] mul_step(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] d
    );
        logic [DATA_W:0] s;
        s = {1'b0, a} + (b[0] ? {1'b0, d} : {(DATA_W+1){1'b0}});
        return {s, b[DATA_W-1:1]};
    endfunction

    // One restoring-division step. The remainder stays below the divisor, so the
    // shifted remainder fits DATA_W+1 bits and the sign of the difference decides.
    function automatic logic [2*DATA_W-1:0] div_step(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] d
    );
        logic [DATA_W:0] sh;
        logic [DATA_W:0] diff;
        sh   = {a, b[DATA_W-1]};
        diff = sh - {1'b0, d};
        if (!diff[DATA_W])
            return {diff[DATA_W-1:0], b[DATA_W-2:0], 1'b1};
        else
            return {sh[DATA_W-1:0], b[DATA_W-2:0], 1'b0};
    endfunction

    // Reset forces busy low so upstream sees a quiet stage while reset is held.
    assign busy = rst && ((state != S_IDLE) || stall_in);

    // Operand select, branch target, ALU and MFHI/MFLO result, accept decode.
    always_comb begin
        op2       = aluSrc ? signExtend : reg2;
        br_target = pcPlusFour + {signExtend[DATA_W-3:0], 2'b00};
        alu_out   = alu_calc(ALUOp, signExtend[5:0], reg1, op2);
        is_mul    = (mduOp == 3'b001);
        is_div    = (mduOp == 3'b010);
        accept    = in_valid && !busy && !flush;
        case (mduOp)
            3'b011:  ex_result = hi;
            3'b100:  ex_result = lo;
            default: ex_result = alu_out;
        endcase
    end

    // MDU state machine, HI/LO and the EX/MEM output register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            hi           <= '0;
            lo           <= '0;
            wa           <= '0;
            wb           <= '0;
            wd           <= '0;
            lat_add      <= '0;
            lat_reg2     <= '0;
            out_valid    <= 1'b0;
            addResult    <= '0;
            aluResult    <= '0;
            reg2Out      <= '0;
            zero         <= 1'b0;
            muxRegDstOut <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && (is_mul || is_div)) begin
                        lat_add  <= br_target;
                        lat_reg2 <= reg2;
                        cnt      <= '0;
                        wd       <= reg2;
                        if (is_mul) begin
                            wa    <= '0;
                            wb    <= reg1;
                            state <= S_MUL;
                        end else if (reg2 == '0) begin
                            wa    <= reg1;
                            wb    <= '1;
                            state <= S_DONE;
                        end else begin
                            wa    <= '0;
                            wb    <= reg1;
                            state <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    {wa, wb} <= mul_step(wa, wb, wd);
                    if (cnt == CNT_LAST) state <= S_DONE;
                    else                 cnt   <= cnt + 1'b1;
                end
                S_DIV: begin
                    {wa, wb} <= div_step(wa, wb, wd);
                    if (cnt == CNT_LAST) state <= S_DONE;
                    else                 cnt   <= cnt + 1'b1;
                end
                S_DONE: begin
                    if (!stall_in) begin
                        hi    <= wa;
                        lo    <= wb;
                        cnt   <= '0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // A stalled MEM stage freezes the output register entirely.
            if (!stall_in) begin
                if (accept && !(is_mul || is_div)) begin
                    out_valid    <= 1'b1;
                    addResult    <= br_target;
                    aluResult    <= ex_result;
                    zero         <= (ex_result == '0);
                    reg2Out      <= reg2;
                    muxRegDstOut <= regDst ? regDst2 : regDst1;
                end else if (state == S_DONE) begin
                    out_valid    <= 1'b1;
                    addResult    <= lat_add;
                    aluResult    <= wb;
                    zero         <= 1'b0;
                    reg2Out      <= lat_reg2;
                    muxRegDstOut <= '0;
                end else begin
                    out_valid    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_execute_stage_mdu.sv
// Directed bench for execute_stage_mdu with an expected-result scoreboard.
module tb_execute_stage_mdu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        stall_in;
    logic        flush;
    logic        aluSrc;
    logic        regDst;
    logic [5:0]  ALUOp;
    logic [2:0]  mduOp;
    logic [31:0] pcPlusFour;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] signExtend;
    logic [4:0]  regDst1;
    logic [4:0]  regDst2;
    logic        busy;
    logic        out_valid;
    logic [31:0] addResult;
    logic [31:0] aluResult;
    logic [31:0] reg2Out;
    logic        zero;
    logic [4:0]  muxRegDstOut;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] add;
        logic        z;
        logic [31:0] r2;
        logic [4:0]  dst;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    execute_stage_mdu #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall_in(stall_in), .flush(flush),
        .aluSrc(aluSrc), .regDst(regDst), .ALUOp(ALUOp), .mduOp(mduOp),
        .pcPlusFour(pcPlusFour), .reg1(reg1), .reg2(reg2), .signExtend(signExtend),
        .regDst1(regDst1), .regDst2(regDst2), .busy(busy), .out_valid(out_valid),
        .addResult(addResult), .aluResult(aluResult), .reg2Out(reg2Out), .zero(zero),
        .muxRegDstOut(muxRegDstOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] br(input logic [31:0] pc, input logic [31:0] se);
        return pc + (se << 2);
    endfunction

    task automatic push(input logic [31:0] alu, input logic [31:0] add, input logic z,
                        input logic [31:0] r2, input logic [4:0] dst);
        exp_t e;
        e.alu = alu; e.add = add; e.z = z; e.r2 = r2; e.dst = dst;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [5:0] op, input logic src, input logic rd,
                         input logic [2:0] mdu, input logic [31:0] pc, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] se,
                         input logic [4:0] d1, input logic [4:0] d2);
        ALUOp = op; aluSrc = src; regDst = rd; mduOp = mdu; pcPlusFour = pc;
        reg1 = r1; reg2 = r2; signExtend = se; regDst1 = d1; regDst2 = d2;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mduOp    = 3'b000;
    endtask

    // Counts cycles with busy high, starting right after the accepting edge.
    task automatic wait_busy(output int cyc);
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    // Output monitor: a loaded EX/MEM register is compared against the scoreboard head.
    always begin
        logic ld;
        exp_t e;
        @(posedge clk);
        ld = rst && !stall_in && !flush;
        #1;
        if (ld && out_valid) begin
            n_assert++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_output: observed aluResult %h with no result pending", aluResult);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("out_alu", 64'(aluResult), 64'(e.alu));
                check("out_add", 64'(addResult), 64'(e.add));
                check("out_zero", 64'(zero), 64'(e.z));
                check("out_reg2", 64'(reg2Out), 64'(e.r2));
                check("out_dst", 64'(muxRegDstOut), 64'(e.dst));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic [63:0] prod;
        logic        seen;

        in_valid = 0; stall_in = 0; flush = 0; aluSrc = 0; regDst = 0; ALUOp = 0;
        mduOp = 0; pcPlusFour = 0; reg1 = 0; reg2 = 0; signExtend = 0; regDst1 = 0; regDst2 = 0;
        rst = 1'b0;

        // Reset with random inputs on the pins
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'($urandom); stall_in = 1'($urandom); flush = 1'($urandom);
            aluSrc = 1'($urandom); regDst = 1'($urandom); ALUOp = 6'($urandom);
            mduOp = 3'($urandom); pcPlusFour = $urandom; reg1 = $urandom; reg2 = $urandom;
            signExtend = $urandom; regDst1 = 5'($urandom); regDst2 = 5'($urandom);
            @(posedge clk); #1;
        end
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_alu", 64'(aluResult), 64'(0));
        check("rst_add", 64'(addResult), 64'(0));
        check("rst_reg2", 64'(reg2Out), 64'(0));
        check("rst_zero", 64'(zero), 64'(0));
        check("rst_dst", 64'(muxRegDstOut), 64'(0));
        in_valid = 0; stall_in = 0; flush = 0; mduOp = 0;
        rst = 1'b1;

        // MFHI after reset reads zero
        push(32'd0, br(32'h100, 32'd4), 1'b1, 32'h55, 5'd2);
        issue(6'h00, 1'b0, 1'b0, 3'b011, 32'h100, 32'h0, 32'h55, 32'd4, 5'd2, 5'd9);
        check("mfhi_rst_valid", 64'(out_valid), 64'(1));

        // Back-to-back ALU operations, one result per cycle
        push(32'd12, br(32'h1000, 32'h20), 1'b0, 32'd7, 5'd3);
        issue(6'h00, 1'b0, 1'b1, 3'b000, 32'h1000, 32'd5, 32'd7, 32'h20, 5'd1, 5'd3);
        check("add_valid", 64'(out_valid), 64'(1));
        push(32'd0, br(32'h1004, 32'h22), 1'b1, 32'd7, 5'd4);
        issue(6'h00, 1'b0, 1'b0, 3'b000, 32'h1004, 32'd7, 32'd7, 32'h22, 5'd4, 5'd8);
        check("sub_valid", 64'(out_valid), 64'(1));
        push(32'd0, 32'h0000_1004, 1'b1, 32'hAA, 5'd7);
        issue(6'h08, 1'b1, 1'b1, 3'b000, 32'h1008, 32'd1, 32'hAA, 32'hFFFF_FFFF, 5'd6, 5'd7);
        check("addi_wrap_valid", 64'(out_valid), 64'(1));
        push(32'd1, 32'h0000_00A4, 1'b0, 32'd3, 5'd31);
        issue(6'h00, 1'b0, 1'b1, 3'b000, 32'hFFFF_FFFC, 32'hFFFF_FFFE, 32'd3, 32'h2A, 5'd0, 5'd31);
        check("slt_valid", 64'(out_valid), 64'(1));
        push(32'hFF, br(32'h1010, 32'hF0), 1'b0, 32'd9, 5'd5);
        issue(6'h0D, 1'b1, 1'b0, 3'b000, 32'h1010, 32'h0F, 32'd9, 32'hF0, 5'd5, 5'd6);
        check("ori_valid", 64'(out_valid), 64'(1));

        // MULTU all-ones squared, with ignored traffic on the inputs while busy
        push(32'h0000_0001, br(32'h2000, 32'h10), 1'b0, 32'hFFFF_FFFF, 5'd0);
        issue(6'h00, 1'b0, 1'b1, 3'b001, 32'h2000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h10, 5'd3, 5'd4);
        in_valid = 1'b1; ALUOp = 6'h00; signExtend = 32'h20; reg1 = 32'h1234; reg2 = 32'h4321;
        wait_busy(cyc);
        in_valid = 1'b0;
        check("mul_busy_cycles", 64'(cyc), 64'(33));
        push(32'hFFFF_FFFE, br(32'h2004, 32'd1), 1'b0, 32'd0, 5'd10);
        issue(6'h00, 1'b0, 1'b0, 3'b011, 32'h2004, 32'd0, 32'd0, 32'd1, 5'd10, 5'd11);
        push(32'h0000_0001, br(32'h2008, 32'd1), 1'b0, 32'd0, 5'd12);
        issue(6'h00, 1'b0, 1'b1, 3'b100, 32'h2008, 32'd0, 32'd0, 32'd1, 5'd11, 5'd12);

        // DIVU 100/7 and divide by zero
        push(32'd100 / 32'd7, br(32'h3000, 32'd2), 1'b0, 32'd7, 5'd0);
        issue(6'h00, 1'b0, 1'b0, 3'b010, 32'h3000, 32'd100, 32'd7, 32'd2, 5'd1, 5'd2);
        wait_busy(cyc);
        check("div_busy_cycles", 64'(cyc), 64'(33));
        push(32'd100 % 32'd7, br(32'h3004, 32'd0), 1'b0, 32'd0, 5'd13);
        issue(6'h00, 1'b0, 1'b0, 3'b011, 32'h3004, 32'd0, 32'd0, 32'd0, 5'd13, 5'd14);
        push(32'hFFFF_FFFF, br(32'h3008, 32'd3), 1'b0, 32'd0, 5'd0);
        issue(6'h00, 1'b0, 1'b0, 3'b010, 32'h3008, 32'd9, 32'd0, 32'd3, 5'd1, 5'd2);
        wait_busy(cyc);
        check("div0_busy_cycles", 64'(cyc), 64'(1));
        push(32'd9, br(32'h300C, 32'd0), 1'b0, 32'd0, 5'd15);
        issue(6'h00, 1'b0, 1'b0, 3'b011, 32'h300C, 32'd0, 32'd0, 32'd0, 5'd15, 5'd16);

        // MULTU with MEM stall from cycle 10 until well past completion
        prod = 64'(32'h1234_5678) * 64'(32'h9ABC_DEF0);
        push(prod[31:0], br(32'h4000, 32'd5), 1'b0, 32'h9ABC_DEF0, 5'd0);
        issue(6'h00, 1'b0, 1'b0, 3'b001, 32'h4000, 32'h1234_5678, 32'h9ABC_DEF0, 32'd5, 5'd1, 5'd2);
        repeat (10) begin @(posedge clk); #1; end
        stall_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid || !busy) seen = 1'b1;
        end
        check("stall_hold", 64'(seen), 64'(0));
        stall_in = 1'b0;
        @(posedge clk); #1;
        check("stall_release_valid", 64'(out_valid), 64'(1));
        check("stall_release_busy", 64'(busy), 64'(0));
        push(prod[63:32], br(32'h4004, 32'd0), 1'b0, 32'd0, 5'd17);
        issue(6'h00, 1'b0, 1'b0, 3'b011, 32'h4004, 32'd0, 32'd0, 32'd0, 5'd17, 5'd18);

        // Flush squashes a valid ALU result and blocks the accept
        push(32'd3, br(32'h5000, 32'h21), 1'b0, 32'd2, 5'd20);
        issue(6'h00, 1'b0, 1'b0, 3'b000, 32'h5000, 32'd1, 32'd2, 32'h21, 5'd20, 5'd21);
        check("pre_flush_valid", 64'(out_valid), 64'(1));
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        check("flush_alu_valid", 64'(out_valid), 64'(0));
        check("flush_alu_busy", 64'(busy), 64'(0));
        in_valid = 1'b0; flush = 1'b0;

        // Flush ten cycles into a DIVU
        issue(6'h00, 1'b0, 1'b0, 3'b010, 32'h6000, 32'd1000, 32'd3, 32'd0, 5'd1, 5'd2);
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_div_valid", 64'(out_valid), 64'(0));
        check("flush_div_busy", 64'(busy), 64'(0));
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid || busy) seen = 1'b1;
        end
        check("flush_div_quiet", 64'(seen), 64'(0));
        push(prod[63:32], br(32'h6004, 32'd0), 1'b0, 32'd0, 5'd22);
        issue(6'h00, 1'b0, 1'b0, 3'b011, 32'h6004, 32'd0, 32'd0, 32'd0, 5'd22, 5'd23);
        push(prod[31:0], br(32'h6008, 32'd0), 1'b0, 32'd0, 5'd24);
        issue(6'h00, 1'b0, 1'b0, 3'b100, 32'h6008, 32'd0, 32'd0, 32'd0, 5'd24, 5'd25);

        // Reset in the middle of a MULTU clears HI/LO
        issue(6'h00, 1'b0, 1'b0, 3'b001, 32'h7000, 32'd7, 32'd9, 32'd0, 5'd1, 5'd2);
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("rst_mid_valid", 64'(out_valid), 64'(0));
        check("rst_mid_busy", 64'(busy), 64'(0));
        push(32'd0, br(32'h7004, 32'd0), 1'b1, 32'd0, 5'd26);
        issue(6'h00, 1'b0, 1'b0, 3'b011, 32'h7004, 32'd0, 32'd0, 32'd0, 5'd26, 5'd27);
        push(32'd0, br(32'h7008, 32'd0), 1'b1, 32'd0, 5'd28);
        issue(6'h00, 1'b0, 1'b0, 3'b100, 32'h7008, 32'd0, 32'd0, 32'd0, 5'd28, 5'd29);

        repeat (3) begin @(posedge clk); #1; end
        check("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
